// File: rtl/nn_mem_seq_ctrl.sv
// nn_mem_seq_ctrl: learn/classify sequencer driving the kernel and weight dual-port memories
module nn_mem_seq_ctrl #(
  parameter int ADDR_W      = 5,
  parameter int LEARN_DEPTH = 4,
  parameter int CLS_STEPS   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              learn,
  input  logic              classify,
  input  logic              clr,
  input  logic [ADDR_W-1:0] cls_kbase,
  output logic [ADDR_W-1:0] kmem_add1,
  output logic [ADDR_W-1:0] kmem_add2,
  output logic              kmem_web1,
  output logic              kmem_oeb1,
  output logic              kmem_csb1,
  output logic              kmem_web2,
  output logic              kmem_oeb2,
  output logic              kmem_csb2,
  output logic [ADDR_W-1:0] wmem_add1,
  output logic [ADDR_W-1:0] wmem_add2,
  output logic              wmem_web1,
  output logic              wmem_oeb1,
  output logic              wmem_csb1,
  output logic              wmem_web2,
  output logic              wmem_oeb2,
  output logic              wmem_csb2,
  output logic              en,
  output logic              cls_done,
  output logic              learn_full,
  output logic [ADDR_W-1:0] learn_cnt,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, LEARN, CLASSIFY, DONE} state_t;
  localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(LEARN_DEPTH);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(CLS_STEPS - 1);
  state_t state, state_n;
  logic [ADDR_W-1:0] ptr, ptr_n, step, step_n, kbase, kbase_n;
  logic full;
  assign full = ptr == DEPTH;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      step  <= '0;
      kbase <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      step  <= step_n;
      kbase <= kbase_n;
    end
  end
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    step_n  = step;
    kbase_n = kbase;
    case (state)
      IDLE: begin
        ptr_n   = clr ? '0 : ptr;
        state_n = learn ? LEARN : classify ? CLASSIFY : IDLE;
      end
      LEARN: begin
        ptr_n   = full ? ptr : ptr + 1'b1;
        state_n = learn ? LEARN : classify ? CLASSIFY : IDLE;
      end
      CLASSIFY: begin
        step_n  = step + 1'b1;
        state_n = learn ? LEARN : !classify ? IDLE : step == LAST ? DONE : CLASSIFY;
      end
      default: state_n = learn ? LEARN : classify ? CLASSIFY : IDLE;
    endcase
    // entering CLASSIFY from anywhere else starts a fresh run
    if (state_n == CLASSIFY && state != CLASSIFY) begin
      kbase_n = cls_kbase;
      step_n  = '0;
    end
  end
  always_comb begin
    kmem_add1 = '0;
    kmem_add2 = '0;
    kmem_web1 = 1'b1;
    kmem_oeb1 = 1'b1;
    kmem_csb1 = 1'b1;
    kmem_web2 = 1'b1;
    kmem_oeb2 = 1'b1;
    kmem_csb2 = 1'b1;
    wmem_add1 = '0;
    wmem_add2 = '0;
    wmem_web1 = 1'b1;
    wmem_oeb1 = 1'b1;
    wmem_csb1 = 1'b1;
    wmem_web2 = 1'b1;
    wmem_oeb2 = 1'b1;
    wmem_csb2 = 1'b1;
    en        = 1'b0;
    cls_done  = 1'b0;
    if (state == LEARN && !full) begin
      kmem_add1 = ptr;
      kmem_web1 = 1'b0;
      kmem_csb1 = 1'b0;
      wmem_add1 = {ptr[ADDR_W-2:0], 1'b0};
      wmem_add2 = {ptr[ADDR_W-2:0], 1'b1};
      wmem_web1 = 1'b0;
      wmem_csb1 = 1'b0;
      wmem_web2 = 1'b0;
      wmem_csb2 = 1'b0;
    end
    if (state == CLASSIFY) begin
      kmem_add1 = kbase;
      kmem_add2 = kbase + 1'b1;
      kmem_oeb1 = 1'b0;
      kmem_csb1 = 1'b0;
      kmem_oeb2 = 1'b0;
      kmem_csb2 = 1'b0;
      wmem_add1 = step;
      wmem_oeb1 = 1'b0;
      wmem_csb1 = 1'b0;
      en        = step == '0;
    end
    cls_done = state == DONE;
  end
  assign learn_full = full;
  assign learn_cnt  = ptr;
  assign busy       = state != IDLE;
endmodule

// File: tb/tb_nn_mem_seq_ctrl.sv
// tb_nn_mem_seq_ctrl: directed scenario checks of the memory sequencer
module tb_nn_mem_seq_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, learn = 1'b0, classify = 1'b0, clr = 1'b0;
  logic [4:0] cls_kbase = '0;
  logic [4:0] kmem_add1, kmem_add2, wmem_add1, wmem_add2, learn_cnt;
  logic kmem_web1, kmem_oeb1, kmem_csb1, kmem_web2, kmem_oeb2, kmem_csb2;
  logic wmem_web1, wmem_oeb1, wmem_csb1, wmem_web2, wmem_oeb2, wmem_csb2;
  logic en, cls_done, learn_full, busy;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  nn_mem_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .learn(learn), .classify(classify), .clr(clr), .cls_kbase(cls_kbase),
    .kmem_add1(kmem_add1), .kmem_add2(kmem_add2),
    .kmem_web1(kmem_web1), .kmem_oeb1(kmem_oeb1), .kmem_csb1(kmem_csb1),
    .kmem_web2(kmem_web2), .kmem_oeb2(kmem_oeb2), .kmem_csb2(kmem_csb2),
    .wmem_add1(wmem_add1), .wmem_add2(wmem_add2),
    .wmem_web1(wmem_web1), .wmem_oeb1(wmem_oeb1), .wmem_csb1(wmem_csb1),
    .wmem_web2(wmem_web2), .wmem_oeb2(wmem_oeb2), .wmem_csb2(wmem_csb2),
    .en(en), .cls_done(cls_done), .learn_full(learn_full), .learn_cnt(learn_cnt), .busy(busy)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    logic [19:0] got;
    #2;
    got = {kmem_add1, kmem_add2, wmem_add1, wmem_add2};
    tests++; if (got !== 20'd0) begin fails++; $display("FAIL reset_addr got=%h exp=0", got); end
    got = {8'd0, kmem_web1, kmem_oeb1, kmem_csb1, kmem_web2, kmem_oeb2, kmem_csb2,
           wmem_web1, wmem_oeb1, wmem_csb1, wmem_web2, wmem_oeb2, wmem_csb2};
    tests++; if (got !== 20'hfff) begin fails++; $display("FAIL reset_strobes got=%h exp=fff", got); end
    got = {12'd0, en, cls_done, learn_full, busy, 4'd0};
    tests++; if (got !== 20'd0 || learn_cnt !== 5'd0) begin fails++; $display("FAIL reset_flags got=%h cnt=%0d exp=0", got, learn_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_learn;
    learn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      tests++; if (kmem_add1 !== 5'(i) || kmem_web1 !== 1'b0 || kmem_csb1 !== 1'b0 || kmem_csb2 !== 1'b1)
        begin fails++; $display("FAIL learn_kmem[%0d] add=%0d web=%b csb=%b%b exp add=%0d web=0 csb=01", i, kmem_add1, kmem_web1, kmem_csb1, kmem_csb2, i); end
      tests++; if (wmem_add1 !== 5'(2*i) || wmem_add2 !== 5'(2*i+1) || {wmem_web1, wmem_csb1, wmem_web2, wmem_csb2} !== 4'b0000)
        begin fails++; $display("FAIL learn_wmem[%0d] add=%0d/%0d strobes=%b%b%b%b exp %0d/%0d 0000", i, wmem_add1, wmem_add2, wmem_web1, wmem_csb1, wmem_web2, wmem_csb2, 2*i, 2*i+1); end
    end
    learn = 1'b0;
    tick;
    tests++; if (busy !== 1'b0 || learn_cnt !== 5'd3 || learn_full !== 1'b0)
      begin fails++; $display("FAIL learn_end busy=%b cnt=%0d full=%b exp 0/3/0", busy, learn_cnt, learn_full); end
  endtask
  task automatic test_append_full;
    learn = 1'b1;
    tick;
    tests++; if (kmem_add1 !== 5'd3 || wmem_add1 !== 5'd6 || wmem_add2 !== 5'd7 || wmem_web1 !== 1'b0 || kmem_web1 !== 1'b0)
      begin fails++; $display("FAIL append_write kadd=%0d wadd=%0d/%0d web=%b%b exp 3 6/7 00", kmem_add1, wmem_add1, wmem_add2, kmem_web1, wmem_web1); end
    for (int i = 0; i < 2; i++) begin
      tick;
      tests++; if (learn_full !== 1'b1 || {kmem_web1, wmem_web1, wmem_web2, kmem_csb1, wmem_csb1, wmem_csb2} !== 6'h3f || learn_cnt !== 5'd4 || busy !== 1'b1)
        begin fails++; $display("FAIL full_hold[%0d] full=%b strobes=%b%b%b%b%b%b cnt=%0d busy=%b exp 1 111111 4 1", i, learn_full, kmem_web1, wmem_web1, wmem_web2, kmem_csb1, wmem_csb1, wmem_csb2, learn_cnt, busy); end
    end
    learn = 1'b0;
    tick;
    tests++; if (learn_cnt !== 5'd4 || busy !== 1'b0) begin fails++; $display("FAIL full_idle cnt=%0d busy=%b exp 4 0", learn_cnt, busy); end
  endtask
  task automatic test_classify;
    cls_kbase = 5'd6;
    classify = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (i == 0) cls_kbase = 5'd20;
      tests++; if (wmem_add1 !== 5'(i) || kmem_add1 !== 5'd6 || kmem_add2 !== 5'd7 || en !== (i == 0) || cls_done !== 1'b0)
        begin fails++; $display("FAIL cls_step[%0d] wadd=%0d kadd=%0d/%0d en=%b done=%b exp %0d 6/7 %b 0", i, wmem_add1, kmem_add1, kmem_add2, en, cls_done, i, i == 0); end
      tests++; if ({kmem_oeb1, kmem_csb1, kmem_web1, kmem_oeb2, kmem_csb2, kmem_web2, wmem_oeb1, wmem_csb1, wmem_web1, wmem_csb2} !== 10'b0010010011)
        begin fails++; $display("FAIL cls_strobes[%0d] got=%b exp=0010010011", i, {kmem_oeb1, kmem_csb1, kmem_web1, kmem_oeb2, kmem_csb2, kmem_web2, wmem_oeb1, wmem_csb1, wmem_web1, wmem_csb2}); end
    end
    tick;
    tests++; if (cls_done !== 1'b1 || kmem_csb1 !== 1'b1 || wmem_csb1 !== 1'b1 || en !== 1'b0)
      begin fails++; $display("FAIL cls_done pulse=%b kcsb=%b wcsb=%b en=%b exp 1 1 1 0", cls_done, kmem_csb1, wmem_csb1, en); end
    tick;
    tests++; if (cls_done !== 1'b0 || en !== 1'b1 || wmem_add1 !== 5'd0 || kmem_add1 !== 5'd20)
      begin fails++; $display("FAIL cls_reenter done=%b en=%b wadd=%0d kadd=%0d exp 0 1 0 20", cls_done, en, wmem_add1, kmem_add1); end
    classify = 1'b0;
    tick;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL cls_exit busy=%b exp 0", busy); end
  endtask
  task automatic test_wrap_abort;
    cls_kbase = 5'd31;
    classify = 1'b1;
    tick;
    tests++; if (kmem_add1 !== 5'd31 || kmem_add2 !== 5'd0) begin fails++; $display("FAIL kbase_wrap kadd=%0d/%0d exp 31/0", kmem_add1, kmem_add2); end
    tick;
    learn = 1'b1;
    tick;
    tests++; if (cls_done !== 1'b0 || busy !== 1'b1 || kmem_oeb1 !== 1'b1 || en !== 1'b0)
      begin fails++; $display("FAIL abort_learn done=%b busy=%b koeb=%b en=%b exp 0 1 1 0", cls_done, busy, kmem_oeb1, en); end
    learn = 1'b0;
    classify = 1'b0;
    tick;
    classify = 1'b1;
    tick;
    tick;
    tests++; if (wmem_add1 !== 5'd1 || en !== 1'b0) begin fails++; $display("FAIL abort_step1 wadd=%0d en=%b exp 1 0", wmem_add1, en); end
    classify = 1'b0;
    tick;
    tests++; if (busy !== 1'b0 || cls_done !== 1'b0) begin fails++; $display("FAIL abort_drop busy=%b done=%b exp 0 0", busy, cls_done); end
  endtask
  task automatic test_clr;
    clr = 1'b1;
    tick;
    tests++; if (learn_cnt !== 5'd0 || learn_full !== 1'b0) begin fails++; $display("FAIL clr_idle cnt=%0d full=%b exp 0 0", learn_cnt, learn_full); end
    clr = 1'b0;
    learn = 1'b1;
    tick;
    tick;
    clr = 1'b1;
    tick;
    tests++; if (learn_cnt !== 5'd2 || kmem_add1 !== 5'd2) begin fails++; $display("FAIL clr_learn cnt=%0d kadd=%0d exp 2 2", learn_cnt, kmem_add1); end
    clr = 1'b0;
  endtask
  task automatic test_reset_mid;
    tests++; if (kmem_web1 !== 1'b0) begin fails++; $display("FAIL pre_reset_write web=%b exp 0", kmem_web1); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if ({kmem_web1, wmem_web1, wmem_web2} !== 3'b111 || busy !== 1'b0 || learn_cnt !== 5'd0)
      begin fails++; $display("FAIL reset_mid web=%b%b%b busy=%b cnt=%0d exp 111 0 0", kmem_web1, wmem_web1, wmem_web2, busy, learn_cnt); end
    learn = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    tests++; if (busy !== 1'b0 || learn_cnt !== 5'd0) begin fails++; $display("FAIL post_reset busy=%b cnt=%0d exp 0 0", busy, learn_cnt); end
  endtask
  initial begin
    test_reset;
    test_learn;
    test_append_full;
    test_classify;
    test_wrap_abort;
    test_clr;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/nn_mem_seq_ctrl.md
Name: nn_mem_seq_ctrl

Overview:
- Parametrised memory sequencer for the neural-net datapath. It drives one dual-port kernel memory (KMEM) and one dual-port weight memory (WMEM) through learn (write) and classify (read) phases.
- Generalises the fixed 2-bit-counter controller: parametrised address width, learn depth and classify length.
- Adds a persistent append pointer, a full flag, a selectable kernel pair, per-port chip-select gating and a classify-done pulse.

Parameters:
ADDR_W, 5, address width of every memory port
LEARN_DEPTH, 4, max learn entries; constraint 2*LEARN_DEPTH <= 2**ADDR_W
CLS_STEPS, 4, weight reads per classify run; constraint 2 <= CLS_STEPS <= 2**ADDR_W

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
learn  in  1  request learn phase; has priority over classify
classify  in  1  request classify phase; must be held for the whole run
clr  in  1  clears the learn pointer; honoured in IDLE only
cls_kbase  in  ADDR_W  kernel-pair base address; latched on entry to CLASSIFY
kmem_add1, kmem_add2  out  ADDR_W  KMEM port 1/2 addresses
kmem_web1, kmem_oeb1, kmem_csb1, kmem_web2, kmem_oeb2, kmem_csb2  out  1 each  KMEM port strobes, active-low
wmem_add1, wmem_add2  out  ADDR_W  WMEM port 1/2 addresses
wmem_web1, wmem_oeb1, wmem_csb1, wmem_web2, wmem_oeb2, wmem_csb2  out  1 each  WMEM port strobes, active-low
en  out  1  start-of-classify strobe to the datapath
cls_done  out  1  one-cycle pulse when a classify run completes
learn_full  out  1  learn pointer has reached LEARN_DEPTH
learn_cnt  out  ADDR_W  number of stored learn entries
busy  out  1  state is not IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, ptr=0, step=0, kbase=0.
- Outputs are Moore-decoded from registered state and counters only. No combinational path from any input to any output.
- Port defaults (all states): web=1, oeb=1, csb=1, addresses 0, en=0, cls_done=0.
- IDLE:
  - All ports deselected.
  - learn=1 -> LEARN.
  - else classify=1 -> CLASSIFY; latch kbase, step=0.
  - clr=1 sets ptr=0. clr is ignored in every other state.
- LEARN, ptr<LEARN_DEPTH, one write per cycle:
  - kmem_add1=ptr, web1=0, csb1=0; KMEM port 2 deselected.
  - wmem_add1=2*ptr, wmem_add2=2*ptr+1, both ports web=0, csb=0.
  - ptr increments every LEARN cycle.
- LEARN, ptr==LEARN_DEPTH: learn_full=1, all ports deselected, ptr holds. There is no wrap-around and no overwrite.
- LEARN exit, evaluated each cycle:
  - learn=1 -> stay.
  - else classify=1 -> CLASSIFY (latch kbase, step=0).
  - else -> IDLE.
- Write count: learn high for N consecutive cycles starting from IDLE gives exactly min(N, LEARN_DEPTH-ptr0) writes. ptr persists across learn bursts (append).
- CLASSIFY:
  - KMEM both ports read: kmem_add1=kbase, kmem_add2=kbase+1 (mod 2**ADDR_W), oeb=0, csb=0, web=1.
  - WMEM port 1 read: wmem_add1=step, oeb1=0, csb1=0; WMEM port 2 deselected.
  - en=1 iff step==0.
  - step increments each cycle.
- CLASSIFY exit, priority order:
  - learn=1 -> LEARN (abort; no cls_done).
  - else classify=0 -> IDLE (abort; no cls_done).
  - else step==CLS_STEPS-1 -> DONE.
  - else stay.
- DONE (one cycle):
  - cls_done=1, all ports deselected.
  - Next state: learn=1 -> LEARN; else classify=1 -> CLASSIFY (re-latch kbase, step=0); else IDLE.
- Widths: ptr and step are ADDR_W bits. 2*ptr+1 is truncated to ADDR_W; the parameter constraint guarantees it fits. learn_cnt=ptr.
- Reset mid-operation: immediate return to the reset values above. The memory write in progress that cycle is dropped because web is forced to 1 asynchronously.

Test Plan:
- Reset, then learn=1 for 3 cycles -> LEARN for 3 cycles. kmem_add1=0,1,2; wmem_add1/2=0/1, 2/3, 4/5. learn_cnt=3, learn_full=0.
- Learn again for 3 cycles (append) -> one write at ptr=3 (wmem 6/7). Then learn_full=1 and web stays high for 2 cycles. learn_cnt=4.
- IDLE, cls_kbase=6, classify held 6 cycles -> 4 CLASSIFY cycles with wmem_add1=0..3 and kmem_add1/2=6/7. en=1 only in the first cycle. cls_done pulses in cycle 5, then re-enters CLASSIFY.
- cls_kbase=31 -> kmem_add2 wraps to 0.
- Mid-classify (step=1): assert learn -> next cycle is LEARN, no cls_done. Drop classify instead -> IDLE, no cls_done.
- clr=1 in IDLE -> learn_cnt=0, learn_full=0. clr=1 in LEARN -> ignored.
- rst_n pulsed low during a LEARN write -> all web=1 immediately, busy=0, learn_cnt=0.
